// File: rtl/fp32_to_fxp_quantizer.sv
// fp32_to_fxp_quantizer
// Streaming IEEE-754 single-precision to signed fixed-point converter.
// Two register stages (unpack/classify, then shift/round/saturate) with
// valid/ready on both sides. Rounding is to nearest, ties away from zero;
// out-of-range values, infinities and NaNs saturate and raise out_sat.
// Optional feature macro: FXP_QUANT_STATS_EN builds the saturation-event
// counter (sat_count / sat_clr); without it sat_count reads 0.
module fp32_to_fxp_quantizer #(
    parameter int FXP_WIDTH     = 32,
    parameter int FRAC_BITS     = 16,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FXP_WIDTH-1:0]     out_data,
    output logic                     out_sat,
    input  logic                     sat_clr,
    output logic [SAT_CNT_WIDTH-1:0] sat_count
);

    localparam logic [FXP_WIDTH-1:0] POS_MAX = {1'b0, {(FXP_WIDTH-1){1'b1}}};
    localparam logic [FXP_WIDTH-1:0] NEG_MIN = {1'b1, {(FXP_WIDTH-1){1'b0}}};
    localparam logic [63:0]          LIM_POS = (64'd1 << (FXP_WIDTH-1)) - 64'd1;
    localparam logic [63:0]          LIM_NEG = 64'd1 << (FXP_WIDTH-1);

    // Stage 1 registers: classified operand
    logic              s1_valid_q;
    logic              s1_sign_q,     s1_sign_d;
    logic [23:0]       s1_mant_q,     s1_mant_d;
    logic signed [9:0] s1_sh_q,       s1_sh_d;
    logic              s1_spec_q,     s1_spec_d;
    logic              s1_spec_neg_q, s1_spec_neg_d;

    // Stage 2 registers: the presented result
    logic                 out_valid_q;
    logic [FXP_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_sat_q,  out_sat_d;

    logic ld2;
    logic [7:0]  exp_in;
    logic [22:0] frac_in;
    logic [63:0] mag;
    logic [9:0]  nsh;

    // A stage may load when empty or when its occupant leaves this cycle
    assign ld2      = !out_valid_q | out_ready;
    assign in_ready = !s1_valid_q | ld2;
    assign exp_in   = in_data[30:23];
    assign frac_in  = in_data[22:0];

    // Unpack: hidden bit, shift amount relative to the output LSB, specials
    always_comb begin
        s1_sign_d     = in_data[31];
        s1_mant_d     = (exp_in != 8'd0 && exp_in != 8'd255) ? {1'b1, frac_in} : 24'd0;
        s1_sh_d       = $signed({2'b00, exp_in}) - 10'sd150 + $signed(10'(FRAC_BITS));
        s1_spec_d     = (exp_in == 8'd255);
        // NaN goes to +max regardless of sign; only -Inf goes to the minimum
        s1_spec_neg_d = in_data[31] & (frac_in == 23'd0);
    end

    // Stage 1 register update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_mant_q     <= '0;
            s1_sh_q       <= '0;
            s1_spec_q     <= 1'b0;
            s1_spec_neg_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q     <= s1_sign_d;
                s1_mant_q     <= s1_mant_d;
                s1_sh_q       <= s1_sh_d;
                s1_spec_q     <= s1_spec_d;
                s1_spec_neg_q <= s1_spec_neg_d;
            end
        end
    end

    // Shift to the output grid, round half away from zero, saturate by sign
    always_comb begin
        mag        = 64'd0;
        nsh        = 10'd0;
        out_data_d = '0;
        out_sat_d  = 1'b0;
        if (!s1_sh_q[9]) begin
            // Any shift this large already exceeds every legal magnitude
            if (s1_sh_q > 10'sd39)
                mag = (s1_mant_q != 24'd0) ? {64{1'b1}} : 64'd0;
            else
                mag = {40'd0, s1_mant_q} << s1_sh_q[5:0];
        end else begin
            nsh = 10'(-s1_sh_q);
            if (nsh < 10'd25)
                mag = 64'(s1_mant_q >> nsh[4:0]) + 64'(s1_mant_q[5'(nsh[4:0] - 5'd1)]);
        end
        if (s1_spec_q) begin
            out_data_d = s1_spec_neg_q ? NEG_MIN : POS_MAX;
            out_sat_d  = 1'b1;
        end else if (!s1_sign_q) begin
            out_sat_d  = (mag > LIM_POS);
            out_data_d = out_sat_d ? POS_MAX : mag[FXP_WIDTH-1:0];
        end else begin
            // -2^(W-1) itself is representable, so only strictly larger saturates
            out_sat_d  = (mag > LIM_NEG);
            out_data_d = out_sat_d ? NEG_MIN : FXP_WIDTH'(64'd0 - mag);
        end
    end

    // Stage 2 register update; holds while the consumer stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (ld2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= out_data_d;
                out_sat_q  <= out_sat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

`ifdef FXP_QUANT_STATS_EN
    logic [SAT_CNT_WIDTH-1:0] sat_cnt_q;

    // Count delivered saturated words; clear wins, count sticks at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_cnt_q <= '0;
        else if (sat_clr)
            sat_cnt_q <= '0;
        else if (out_valid_q && out_ready && out_sat_q && !(&sat_cnt_q))
            sat_cnt_q <= sat_cnt_q + 1'b1;
    end

    assign sat_count = sat_cnt_q;
`else
    logic unused_sat_clr;
    assign unused_sat_clr = sat_clr;
    assign sat_count      = '0;
`endif

endmodule

// File: tb/tb_fp32_to_fxp_quantizer.sv
// Self-checking bench for fp32_to_fxp_quantizer (FXP_WIDTH=32, FRAC_BITS=16).
// The reference converts each fp32 word to a real, scales it, rounds half
// away from zero and clamps; results are queued in acceptance order.
module tb_fp32_to_fxp_quantizer;

    localparam int W  = 32;
    localparam int F  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_sat;
    logic          sat_clr;
    logic [CW-1:0] sat_count;

    fp32_to_fxp_quantizer #(.FXP_WIDTH(W), .FRAC_BITS(F), .SAT_CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .sat_clr(sat_clr), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W:0]   exp_q[$];       // {sat, data}
    longint       exp_cnt = 0;
    logic         hold_v = 1'b0;
    logic [W-1:0] hold_d;
    logic         hold_s;
    logic         last_ov, last_ir, last_in_fire;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Real-valued reference: value * 2^F, round half away from zero, clamp
    function automatic logic [W:0] model(input logic [31:0] x);
        int          e;
        real         v, sc, p, r;
        logic [63:0] dbits;
        e = int'(x[30:23]);
        if (e == 255)
            return (x[22:0] != 0 || !x[31]) ? {1'b1, 1'b0, {(W-1){1'b1}}}
                                             : {1'b1, 1'b1, {(W-1){1'b0}}};
        if (e == 0)
            return '0;
        dbits = {x[31], 11'(e + 896), x[22:0], 29'd0};
        sc = 1.0;
        repeat (F) sc = sc * 2.0;
        p = 1.0;
        repeat (W-1) p = p * 2.0;
        v = $bitstoreal(dbits) * sc;
        r = (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
        if (r > p - 1.0) return {1'b1, 1'b0, {(W-1){1'b1}}};
        if (r < -p)      return {1'b1, 1'b1, {(W-1){1'b0}}};
        return {1'b0, W'(longint'(r))};
    endfunction

    // One clock: drive after negedge, sample/score mid-cycle, check count after posedge
    task automatic tick(input logic iv, input logic [31:0] id, input logic ordy,
                        input logic clr, input logic use_k, input logic [W:0] kexp);
        logic [W:0] e;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        sat_clr   = clr;
        #1;
        last_ov = out_valid;
        last_ir = in_ready;
        if (hold_v) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_data",  64'(out_data),  64'(hold_d));
            check("hold_sat",   64'(out_sat),   64'(hold_s));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(e[W-1:0]));
                check("out_sat",  64'(out_sat),  64'(e[W]));
                if (clr)
                    exp_cnt = 0;
                else if (e[W] && exp_cnt < (1 << CW) - 1)
                    exp_cnt++;
            end
        end else if (clr) begin
            exp_cnt = 0;
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_s = out_sat;
        last_in_fire = in_valid && in_ready;
        if (last_in_fire) exp_q.push_back(use_k ? kexp : model(id));
        @(posedge clk);
        #1;
`ifdef FXP_QUANT_STATS_EN
        check("sat_count", 64'(sat_count), 64'(exp_cnt));
`else
        check("sat_count", 64'(sat_count), 64'(0));
`endif
    endtask

    task automatic send_k(input logic [31:0] id, input logic [W-1:0] d, input logic s);
        tick(1'b1, id, 1'b1, 1'b0, 1'b1, {s, d});
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    function automatic logic [31:0] rand_fp();
        int   sel;
        logic [7:0] e;
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      e = 8'd0;
        else if (sel == 1) e = 8'd255;
        else               e = 8'($urandom_range(100, 160));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    logic [31:0] bp_words[4];

    initial begin
        int idx;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sat_clr = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data",  64'(out_data),  64'(0));
        check("rst_out_sat",   64'(out_sat),   64'(0));
        check("rst_sat_count", 64'(sat_count), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Latency: result appears two cycles after acceptance
        send_k(32'h3FC00000, 32'h00018000, 1'b0);
        tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, '0);
        check("lat_not_yet", 64'(last_ov), 64'(0));
        tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, '0);
        check("lat_two", 64'(last_ov), 64'(1));

        // Signed values, zeros, rounding at half LSB
        send_k(32'hC0100000, 32'hFFFDC000, 1'b0);
        send_k(32'h00000000, 32'h00000000, 1'b0);
        send_k(32'h80000000, 32'h00000000, 1'b0);
        send_k(32'h37000000, 32'h00000001, 1'b0);
        send_k(32'h36800000, 32'h00000000, 1'b0);
        send_k(32'hB7000000, 32'hFFFFFFFF, 1'b0);
        // Saturation and the representable minimum
        send_k(32'h501502F9, 32'h7FFFFFFF, 1'b1);
        send_k(32'hD01502F9, 32'h80000000, 1'b1);
        send_k(32'hC7000000, 32'h80000000, 1'b0);
        send_k(32'h7FC00000, 32'h7FFFFFFF, 1'b1);
        send_k(32'hFF800000, 32'h80000000, 1'b1);
        idle(3);
`ifdef FXP_QUANT_STATS_EN
        check("sat_count_4", 64'(sat_count), 64'(4));
`endif

        // Backpressure: four words, consumer stalled for five cycles
        bp_words[0] = 32'h3F800000; bp_words[1] = 32'hBF800000;
        bp_words[2] = 32'h40400000; bp_words[3] = 32'h501502F9;
        idx = 0;
        for (int c = 0; c < 30 && (idx < 4 || exp_q.size() != 0); c++) begin
            tick(idx < 4, (idx < 4) ? bp_words[idx] : 32'd0, c >= 5, 1'b0, 1'b0, '0);
            if (c == 2) check("bp_in_ready_low", 64'(last_ir), 64'(0));
            if (last_in_fire) idx++;
        end
        check("bp_accepted", 64'(idx), 64'(4));
        check("bp_drained",  64'(exp_q.size()), 64'(0));

        // sat_clr coincident with a saturated output
        tick(1'b1, 32'h501502F9, 1'b1, 1'b0, 1'b1, {1'b1, 32'h7FFFFFFF});
        tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, '0);
        tick(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, '0);
        check("clr_fire", 64'(last_ov), 64'(1));
        check("clr_count", 64'(sat_count), 64'(0));
        send_k(32'h7FC00000, 32'h7FFFFFFF, 1'b1);
        idle(3);

        // Asynchronous reset with two words in flight
        tick(1'b1, 32'h3FC00000, 1'b0, 1'b0, 1'b0, '0);
        tick(1'b1, 32'hD01502F9, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_sat_count", 64'(sat_count), 64'(0));
        exp_q.delete();
        exp_cnt = 0;
        hold_v = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, '0);
        check("post_rst_idle", 64'(last_ov), 64'(0));
        send_k(32'hC0100000, 32'hFFFDC000, 1'b0);
        tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, '0);
        check("post_rst_lat1", 64'(last_ov), 64'(0));
        tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, '0);
        check("post_rst_lat2", 64'(last_ov), 64'(1));

        // Randomized traffic with random stalls and occasional clears
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 3) != 0, rand_fp(), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 49) == 0, 1'b0, '0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        check("final_drain", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
